// File: rtl/fp32_to_int32.sv
// fp32_to_int32: converts an IEEE-754 single to a signed 32-bit integer,
// rounding toward zero, using a one-bit-per-cycle alignment shifter.
//
// state | meaning
// IDLE  | waiting for a float, in_ready high
// SHIFT | aligning significand one bit per cycle
// FIX   | applying sign (or passing a pre-decided special result) into out regs
// OUT   | result presented, waiting for out_ready
module fp32_to_int32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIX   = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic               sgn;
    logic [31:0]        acc;
    logic signed [5:0]  cnt;
    logic               sticky;
    logic               special;
    logic [2:0]         spec_flags;

    logic        in_sgn;
    logic [7:0]  in_exp;
    logic [22:0] in_man;
    logic        accept;

    logic        cls_special;
    logic [31:0] cls_result;
    logic [2:0]  cls_flags;
    logic [31:0] sat_value;

    assign in_sgn    = in_data[31];
    assign in_exp    = in_data[30:23];
    assign in_man    = in_data[22:0];
    assign accept    = in_valid && in_ready;
    assign sat_value = in_sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;

    // Classify the incoming float; anything outside 127..157 is decided at once.
    always_comb begin
        cls_special = 1'b1;
        cls_result  = 32'h0;
        cls_flags   = 3'b000;
        if (in_exp == 8'd255) begin
            if (in_man != 23'd0) begin
                cls_flags = 3'b100;
            end else begin
                cls_result = sat_value;
                cls_flags  = 3'b010;
            end
        end else if (in_exp >= 8'd158) begin
            cls_result = sat_value;
            if (!(in_exp == 8'd158 && in_sgn && in_man == 23'd0)) begin
                cls_flags = 3'b010;
            end
        end else if (in_exp < 8'd127) begin
            cls_flags = {2'b00, |{in_exp, in_man}};
        end else begin
            cls_special = 1'b0;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = cls_special ? FIX : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 6'sd0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: capture, alignment shifter, and registered result.
    // Special results ride through FIX so every result leaves via one register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn        <= 1'b0;
            acc        <= 32'h0;
            cnt        <= 6'sd0;
            sticky     <= 1'b0;
            special    <= 1'b0;
            spec_flags <= 3'b000;
            out_data   <= 32'h0;
            out_flags  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sgn        <= in_sgn;
                        sticky     <= 1'b0;
                        special    <= cls_special;
                        spec_flags <= cls_flags;
                        cnt        <= 6'(in_exp - 8'd150);
                        if (cls_special) begin
                            acc <= cls_result;
                        end else begin
                            acc <= {8'b0, 1'b1, in_man};
                        end
                    end
                end
                SHIFT: begin
                    if (cnt[5]) begin
                        sticky <= sticky | acc[0];
                        acc    <= acc >> 1;
                        cnt    <= cnt + 6'sd1;
                    end else if (cnt != 6'sd0) begin
                        acc <= acc << 1;
                        cnt <= cnt - 6'sd1;
                    end
                end
                FIX: begin
                    if (special) begin
                        out_data  <= acc;
                        out_flags <= spec_flags;
                    end else begin
                        out_data  <= sgn ? (~acc + 32'd1) : acc;
                        out_flags <= {2'b00, sticky};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
